// File: rtl/serial_adder_16bit_ctrl_pkg.sv
// serial_adder_pkg: shared FSM state type and slice-count constants for the serial adder
package serial_adder_pkg;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    localparam int WIDTH_DEF = 16;
    localparam int NIB_DEF = 4;
    localparam int NSLICE = WIDTH_DEF / NIB_DEF;
    function automatic int nslice(input int w, input int n);
        return w / n;
    endfunction
endpackage

// File: rtl/serial_adder_16bit_ctrl_if.sv
// serial_adder_16bit_ctrl_if: operand/result handshake bundle for the serial adder
interface serial_adder_16bit_ctrl_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             busy;
    modport master (output in_valid, A, B, Cin, out_ready, input in_ready, out_valid, Sum, Cout, busy);
    modport slave (input in_valid, A, B, Cin, out_ready, output in_ready, out_valid, Sum, Cout, busy);
endinterface

// File: rtl/serial_adder_16bit_ctrl_nibble.sv
// nibble_adder: combinational NIB-bit adder slice with carry in/out
module nibble_adder #(parameter int NIB = 4) (
    input  logic [NIB-1:0] a,
    input  logic [NIB-1:0] b,
    input  logic           cin,
    output logic [NIB-1:0] sum,
    output logic           cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + (NIB+1)'(cin);
endmodule

// File: rtl/serial_adder_16bit_ctrl.sv
// serial_adder_16bit_ctrl: adds two WIDTH-bit operands one NIB-bit slice per cycle
module serial_adder_16bit_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NIB = NIB_DEF
) (
    input logic clk,
    input logic rst,
    serial_adder_16bit_ctrl_if.slave bus
);
    localparam int NS = nslice(WIDTH, NIB);
    localparam int IW = NS > 1 ? $clog2(NS) : 1;
    state_t state, next;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [IW-1:0] idx;
    logic carry, cout_q, c_sl, last;
    logic [NIB-1:0] s_sl;
    assign last = idx == IW'(NS - 1);
    nibble_adder #(.NIB(NIB)) u_slice (
        .a(a_q[idx*NIB +: NIB]),
        .b(b_q[idx*NIB +: NIB]),
        .cin(carry),
        .sum(s_sl),
        .cout(c_sl)
    );
    assign bus.Sum = sum_q;
    assign bus.Cout = cout_q;
    // State register; reset overrides any pending operation
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : next;
    end
    // Next-state and handshake outputs
    always_comb begin
        next = state;
        bus.in_ready = state == IDLE;
        bus.out_valid = state == DONE;
        bus.busy = state != IDLE;
        if (state == IDLE && bus.in_valid) next = ADD;
        else if (state == ADD && last) next = DONE;
        else if (state == DONE && bus.out_ready) next = IDLE;
    end
    // Operand capture on acceptance, then one slice per ADD cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            sum_q <= '0;
            idx <= '0;
            carry <= 1'b0;
            cout_q <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            a_q <= bus.A;
            b_q <= bus.B;
            idx <= '0;
            carry <= bus.Cin;
        end else if (state == ADD) begin
            sum_q[idx*NIB +: NIB] <= s_sl;
            carry <= c_sl;
            idx <= idx + IW'(1);
            if (last) cout_q <= c_sl;
        end
    end
endmodule

// File: tb/tb_serial_adder_16bit_ctrl.sv
// tb_serial_adder_16bit_ctrl: directed vectors, backpressure, mid-ADD reset and random stream checks
module tb_serial_adder_16bit_ctrl;
    import serial_adder_pkg::*;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    serial_adder_16bit_ctrl_if #(.WIDTH(16)) bus ();
    serial_adder_16bit_ctrl #(.WIDTH(16), .NIB(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        c;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic cin);
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.Cin = cin;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("busy_in_add", 32'(bus.busy), 1);
    endtask

    task automatic wait_done(input string name, input logic [15:0] s, input logic c);
        int lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, 4);
        chk({name, "_sum"}, 32'(bus.Sum), 32'(s));
        chk({name, "_cout"}, 32'(bus.Cout), 32'(c));
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("idle_after_done", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    endtask

    initial begin
        logic [16:0] q [$];
        logic [16:0] exp;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        vecs[6] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};
        vecs[7] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.Cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_flags", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'b100);
        chk("reset_sum", 32'(bus.Sum), 0);
        chk("reset_cout", 32'(bus.Cout), 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_done($sformatf("vec%0d", i), vecs[i].s, vecs[i].c);
            release_result();
        end
        accept(16'h1234, 16'h1111, 1'b0);
        wait_done("bp", 16'h2345, 1'b0);
        bus.in_valid = 1'b1;
        bus.A = 16'h0001;
        bus.B = 16'h0000;
        bus.Cin = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_flags", {30'd0, bus.out_valid, bus.in_ready}, 32'b10);
            chk("bp_hold_result", {15'd0, bus.Cout, bus.Sum}, 32'h2345);
        end
        bus.in_valid = 1'b0;
        release_result();
        accept(16'h0001, 16'h0000, 1'b0);
        wait_done("after_bp", 16'h0001, 1'b0);
        release_result();
        accept(16'h00FF, 16'h0001, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b0;
        chk("midadd_rst_flags", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'b100);
        chk("midadd_rst_result", {15'd0, bus.Cout, bus.Sum}, 0);
        accept(16'h0002, 16'h0003, 1'b0);
        wait_done("after_rst", 16'h0005, 1'b0);
        release_result();
        while ((sent < 1000 || got < 1000) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            bus.out_ready = $urandom_range(0, 1) == 1;
            bus.in_valid = sent < 1000 && $urandom_range(0, 3) != 0;
            bus.A = $urandom_range(0, 7) == 0 ? 16'hFFFF : 16'($urandom);
            bus.B = $urandom_range(0, 7) == 0 ? 16'hFFFF : 16'($urandom);
            bus.Cin = 1'($urandom);
            #1;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back({1'b0, bus.A} + {1'b0, bus.B} + 17'(bus.Cin));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                exp = q.size() > 0 ? q.pop_front() : 17'h1FFFF;
                chk($sformatf("stream%0d", got), {15'd0, bus.Cout, bus.Sum}, 32'(exp));
                got++;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("stream_completed", got, 1000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_adder_16bit_ctrl.md
SERIAL_ADDER_16BIT_CTRL -- requirements
Module: serial_adder_16bit_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL be a multiple of NIB.
REQ-002 Parameter NIB, default 4, width of the nibble adder slice used per cycle.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  operand set A, B, Cin is offered.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 Cin  input  1  carry into bit 0.
REQ-010 out_valid  output  1  Sum/Cout hold a completed result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 Sum  output  WIDTH  result A+B+Cin, low WIDTH bits.
REQ-013 Cout  output  1  carry out of bit WIDTH-1.
REQ-014 busy  output  1  high in ADD and DONE states.

Function
REQ-015 FSM states SHALL be IDLE, ADD, DONE; encoding is free.
REQ-016 IDLE: in_ready=1; on in_valid at an edge, latch A, B, Cin into operand registers, clear nibble index to 0, load carry register with Cin, go to ADD.
REQ-017 ADD: each cycle adds nibble[idx] of A and B with the carry register through one NIB-bit adder; writes the NIB-bit sum into Sum[idx*NIB +: NIB]; carry register takes the slice carry-out; idx increments.
REQ-018 ADD: on the edge processing idx = WIDTH/NIB-1, Cout SHALL take the slice carry-out and the FSM SHALL go to DONE.
REQ-019 DONE: out_valid=1, Sum and Cout held stable; on out_ready go to IDLE.
REQ-020 Latency: with acceptance at edge T, out_valid SHALL rise after edge T+WIDTH/NIB (4 cycles at defaults).
REQ-021 in_ready SHALL be 0 in ADD and DONE; in_valid there SHALL be ignored and no operand register SHALL change.
REQ-022 No overlap: a new operand set is accepted no earlier than the cycle after the DONE handshake; throughput is one result per WIDTH/NIB+2 cycles when out_ready is held high.
REQ-023 out_ready while not in DONE SHALL have no effect.
REQ-024 Result SHALL equal (A+B+Cin) mod 2^(WIDTH+1), split as {Cout,Sum}, for all inputs including all-ones operands.
REQ-025 Sum bits of not-yet-processed nibbles during ADD are don't-care; only DONE values are architecturally defined.

Reset
REQ-026 rst sampled high at an edge SHALL force IDLE from any state, including mid-ADD and DONE-with-backpressure; the pending operation is discarded.
REQ-027 Reset values: in_ready=1 after the reset edge, out_valid=0, busy=0, Sum=0, Cout=0, idx=0, carry register=0.
REQ-028 rst SHALL take priority over simultaneous in_valid or out_ready.

Structure
REQ-029 FSM state typedef and the derived constant NSLICE=WIDTH/NIB SHALL live in a shared package serial_adder_pkg.
REQ-030 The per-cycle slice SHALL be one sub-module, nibble_adder (NIB-bit A, B, Cin -> NIB-bit Sum, Cout, purely combinational), instantiated exactly once.
REQ-031 Operand shifting or index-based slice selection is free, provided REQ-020 latency holds.

Verification
REQ-032 A=0x1234, B=0x4321, Cin=0 -> after 4 cycles out_valid=1, Sum=0x5555, Cout=0.
REQ-033 A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1 (carry ripples through all 4 slices).
REQ-034 A=0xFFFF, B=0xFFFF, Cin=1 -> Sum=0xFFFF, Cout=1.
REQ-035 out_ready held 0 for 10 cycles in DONE -> Sum/Cout/out_valid stable, in_ready=0, a new in_valid (A=0x0001) ignored; after out_ready=1 the next accepted set gives its own correct result.
REQ-036 rst=1 during second ADD cycle of A=0x00FF, B=0x0001 -> next cycle IDLE, in_ready=1, out_valid=0, Sum=0, Cout=0; following A=0x0002, B=0x0003, Cin=0 -> Sum=0x0005, Cout=0.
REQ-037 Random back-to-back stream, 1000 sets, random out_ready -> every result matches the {Cout,Sum}=A+B+Cin reference model, in order.
